// File: rtl/branch_predict_resolve_pkg.sv
// Shared definitions for the branch predictor / resolver: branch-type codes and
// saturating-counter initial values.
package branch_predict_resolve_pkg;

    typedef enum logic [2:0] {
        BR_NOBRANCH = 3'd0,
        BR_BEQ      = 3'd1,
        BR_BNE      = 3'd2,
        BR_BLT      = 3'd3,
        BR_BLTU     = 3'd4,
        BR_BGE      = 3'd5,
        BR_BGEU     = 3'd6
    } br_type_e;

    localparam int unsigned CNT_W_MAX = 4;

    // Weakly-taken: MSB set, all lower bits clear.
    function automatic logic [CNT_W_MAX-1:0] cnt_weak_taken(input int unsigned w);
        return 4'd1 << (w - 32'd1);
    endfunction

    // Weakly-not-taken: MSB clear, all lower bits set.
    function automatic logic [CNT_W_MAX-1:0] cnt_weak_not_taken(input int unsigned w);
        return cnt_weak_taken(w) - 4'd1;
    endfunction

    function automatic logic is_cond_branch(input logic [2:0] br_type);
        case (br_type)
            BR_BEQ, BR_BNE, BR_BLT, BR_BLTU, BR_BGE, BR_BGEU: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_cond_cmp.sv
// Branch condition evaluation: decides taken/not-taken for the EX-stage branch.
module branch_cond_cmp
    import branch_predict_resolve_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            valid,
    input  logic [2:0]      br_type,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            taken
);

    logic eq_s;
    logic lt_s;
    logic ltu_s;
    logic taken_s;

    assign eq_s  = (op_a == op_b);
    assign lt_s  = ($signed(op_a) < $signed(op_b));
    assign ltu_s = (op_a < op_b);

    // Select the comparison for the branch type; bubbles never take.
    always_comb begin
        taken_s = 1'b0;
        if (valid) begin
            case (br_type)
                BR_BEQ:  taken_s = eq_s;
                BR_BNE:  taken_s = !eq_s;
                BR_BLT:  taken_s = lt_s;
                BR_BGE:  taken_s = !lt_s;
                BR_BLTU: taken_s = ltu_s;
                BR_BGEU: taken_s = !ltu_s;
                default: taken_s = 1'b0;
            endcase
        end else begin
            taken_s = 1'b0;
        end
    end

    assign taken = taken_s;

endmodule

// File: rtl/branch_predict_resolve.sv
// Direct-mapped branch target buffer with saturating counters: predicts at fetch,
// resolves at EX, and trains the table plus branch/mispredict statistics.
module branch_predict_resolve
    import branch_predict_resolve_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 2
) (
    input  logic            CPU_CLK,
    input  logic            CPU_RST_N,
    input  logic [XLEN-1:0] PCF,
    output logic            PredTakenF,
    output logic [XLEN-1:0] PredTargetF,
    input  logic            ValidE,
    input  logic [2:0]      BranchTypeE,
    input  logic [XLEN-1:0] Operand1,
    input  logic [XLEN-1:0] Operand2,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] BranchTargetE,
    input  logic            PredTakenE,
    input  logic [XLEN-1:0] PredTargetE,
    output logic            BranchE,
    output logic            MispredictE,
    output logic [XLEN-1:0] RedirectPCE,
    output logic [31:0]     BrCount,
    output logic [31:0]     MissCount
);

    localparam int IDXW = $clog2(BHT_ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;
    localparam logic [CNT_W-1:0] CNT_WT   = CNT_W'(cnt_weak_taken(CNT_W));
    localparam logic [CNT_W-1:0] CNT_WNT  = CNT_W'(cnt_weak_not_taken(CNT_W));
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  PC_STEP  = {{(XLEN-3){1'b0}}, 3'b100};

    logic            valid_r  [BHT_ENTRIES];
    logic [TAGW-1:0] tag_r    [BHT_ENTRIES];
    logic [XLEN-1:0] target_r [BHT_ENTRIES];
    logic [CNT_W-1:0] cnt_r   [BHT_ENTRIES];
    logic            upd_en_r;
    logic [31:0]     br_count_r;
    logic [31:0]     miss_count_r;

    logic [IDXW-1:0] idx_f_s;
    logic [TAGW-1:0] tag_f_s;
    logic            pred_taken_f_s;
    logic [IDXW-1:0] idx_e_s;
    logic [TAGW-1:0] tag_e_s;
    logic            hit_e_s;
    logic [CNT_W-1:0] cur_cnt_s;
    logic            branch_s;
    logic            mispredict_s;
    logic            cond_s;
    logic            alias_s;
    logic            wr_en_s;
    logic            wr_valid_s;
    logic [TAGW-1:0] wr_tag_s;
    logic [XLEN-1:0] wr_target_s;
    logic [CNT_W-1:0] wr_cnt_s;
    logic            unused_s;

    assign unused_s = ^{PCF[1:0], PCE[1:0]};

    // Fetch lookup reads the stored state only, so a same-cycle update is seen next cycle.
    assign idx_f_s        = PCF[IDXW+1:2];
    assign tag_f_s        = PCF[XLEN-1:IDXW+2];
    assign pred_taken_f_s = valid_r[idx_f_s] && (tag_r[idx_f_s] == tag_f_s) && cnt_r[idx_f_s][CNT_W-1];
    assign PredTakenF     = pred_taken_f_s;
    assign PredTargetF    = pred_taken_f_s ? target_r[idx_f_s] : (PCF + PC_STEP);

    branch_cond_cmp #(.XLEN(XLEN)) u_cmp (
        .valid   (ValidE),
        .br_type (BranchTypeE),
        .op_a    (Operand1),
        .op_b    (Operand2),
        .taken   (branch_s)
    );

    assign mispredict_s = ValidE && ((branch_s != PredTakenE) ||
                                     (branch_s && PredTakenE && (BranchTargetE != PredTargetE)));
    assign BranchE      = branch_s;
    assign MispredictE  = mispredict_s;
    assign RedirectPCE  = branch_s ? BranchTargetE : (PCE + PC_STEP);

    assign idx_e_s   = PCE[IDXW+1:2];
    assign tag_e_s   = PCE[XLEN-1:IDXW+2];
    assign hit_e_s   = valid_r[idx_e_s] && (tag_r[idx_e_s] == tag_e_s);
    assign cur_cnt_s = cnt_r[idx_e_s];
    assign cond_s    = ValidE && is_cond_branch(BranchTypeE);
    assign alias_s   = ValidE && (BranchTypeE == BR_NOBRANCH) && PredTakenE;

    // Compute the new contents of the EX-indexed entry; a not-taken miss leaves it alone.
    always_comb begin
        wr_en_s     = 1'b0;
        wr_valid_s  = valid_r[idx_e_s];
        wr_tag_s    = tag_r[idx_e_s];
        wr_target_s = target_r[idx_e_s];
        wr_cnt_s    = cur_cnt_s;
        if (!upd_en_r) begin
            wr_en_s = 1'b0;
        end else if (cond_s) begin
            if (branch_s) begin
                wr_en_s     = 1'b1;
                wr_valid_s  = 1'b1;
                wr_tag_s    = tag_e_s;
                wr_target_s = BranchTargetE;
                if (hit_e_s) begin
                    wr_cnt_s = (cur_cnt_s == CNT_MAX) ? cur_cnt_s : (cur_cnt_s + CNT_ONE);
                end else begin
                    wr_cnt_s = CNT_WT;
                end
            end else if (hit_e_s) begin
                wr_en_s  = 1'b1;
                wr_cnt_s = (cur_cnt_s == CNT_ZERO) ? cur_cnt_s : (cur_cnt_s - CNT_ONE);
            end else begin
                wr_en_s = 1'b0;
            end
        end else if (alias_s) begin
            wr_en_s    = 1'b1;
            wr_valid_s = 1'b0;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Blocks training on the first edge after reset release.
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            upd_en_r <= 1'b0;
        end else begin
            upd_en_r <= 1'b1;
        end
    end

    // Predictor table storage.
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAGW{1'b0}};
                target_r[i] <= {XLEN{1'b0}};
                cnt_r[i]    <= CNT_WNT;
            end
        end else if (wr_en_s) begin
            valid_r[idx_e_s]  <= wr_valid_s;
            tag_r[idx_e_s]    <= wr_tag_s;
            target_r[idx_e_s] <= wr_target_s;
            cnt_r[idx_e_s]    <= wr_cnt_s;
        end
    end

    // Saturating resolved-branch and mispredict statistics.
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            br_count_r   <= 32'd0;
            miss_count_r <= 32'd0;
        end else begin
            if (upd_en_r && cond_s && (br_count_r != 32'hFFFF_FFFF)) begin
                br_count_r <= br_count_r + 32'd1;
            end
            if (upd_en_r && mispredict_s && (miss_count_r != 32'hFFFF_FFFF)) begin
                miss_count_r <= miss_count_r + 32'd1;
            end
        end
    end

    assign BrCount   = br_count_r;
    assign MissCount = miss_count_r;

endmodule
